cache_controller_nway: RTL and testbench

//  Control FSM for an N-way set-associative cache line slot; successor to the single-way controller.

---
 rtl/cache_controller_nway_if.sv | 46 ++++
 rtl/cache_controller_nway.sv | 249 ++++++++++++++++++++++++
 tb/tb_cache_controller_nway.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_controller_nway_if.sv
// ---------------------------------------------------------------------------
// cache_controller_nway_if
//   Bundle of the request, datapath and ACE signals around the N-way cache
//   controller.
//   master : environment side (CPU, tag/state arrays, ACE engine). It drives
//            cpu_request, way_hit, way_state and ace_ready.
//   slave  : controller side. It drives the ACE requests, the datapath
//            strobes, way_sel and the status pulses.
// ---------------------------------------------------------------------------
interface cache_controller_nway_if #(
    parameter int NUM_WAYS    = 4,
    parameter int WIDTH_STATE = 3
);
    localparam int WIDTH_WAY = $clog2(NUM_WAYS);

    logic [1:0]                      cpu_request;
    logic [NUM_WAYS-1:0]             way_hit;
    logic [NUM_WAYS*WIDTH_STATE-1:0] way_state;
    logic                            ace_ready;

    logic                            read_req;
    logic                            write_req;
    logic                            invalid_req;
    logic                            write_from_cpu;
    logic                            write_from_interconnect;
    logic                            state_sel;
    logic [WIDTH_STATE-1:0]          new_state;
    logic [WIDTH_WAY-1:0]            way_sel;
    logic                            cache_complete;
    logic                            cache_ready;
    logic                            cache_error;

    modport master (
        output cpu_request, way_hit, way_state, ace_ready,
        input  read_req, write_req, invalid_req, write_from_cpu,
               write_from_interconnect, state_sel, new_state, way_sel,
               cache_complete, cache_ready, cache_error
    );

    modport slave (
        input  cpu_request, way_hit, way_state, ace_ready,
        output read_req, write_req, invalid_req, write_from_cpu,
               write_from_interconnect, state_sel, new_state, way_sel,
               cache_complete, cache_ready, cache_error
    );
endinterface

// File: rtl/cache_controller_nway.sv
// ---------------------------------------------------------------------------
// cache_controller_nway
//   Control FSM for an N-way set-associative cache slot. It resolves a hit
//   across NUM_WAYS ways. On a miss it picks a victim: the lowest-index
//   invalid way if there is one, else the round-robin pointer. It then runs
//   the writeback, allocate and invalidate transactions and replays the
//   request.
//
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; forces every output to 0 while high
//   bus    : cache_controller_nway_if.slave
//            in : cpu_request (00 read, 01 write, others no-op), way_hit,
//                 way_state (way k at [k*WIDTH_STATE +: WIDTH_STATE]),
//                 ace_ready (1-cycle completion pulse)
//            out: read_req, write_req and invalid_req (level requests);
//                 write_from_cpu, write_from_interconnect, state_sel,
//                 new_state and way_sel (datapath controls);
//                 cache_complete, cache_ready, cache_error (status)
//
// Configuration
//   CACHE_TIMEOUT_EN : when defined, a wait for ace_ready gives up after
//                      TIMEOUT_CYCLES cycles. The FSM then pulses cache_error
//                      and returns to IDLE. When undefined, waits are
//                      unbounded and cache_error is tied to 0.
// ---------------------------------------------------------------------------
module cache_controller_nway #(
    parameter int NUM_WAYS       = 4,
    parameter int WIDTH_STATE    = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                     clk,
    input logic                     reset,
    cache_controller_nway_if.slave  bus
);
    localparam int WIDTH_WAY = $clog2(NUM_WAYS);

    localparam logic [WIDTH_STATE-1:0] ST_UC = WIDTH_STATE'(3'b000);
    localparam logic [WIDTH_STATE-1:0] ST_UD = WIDTH_STATE'(3'b001);
    localparam logic [WIDTH_STATE-1:0] ST_SC = WIDTH_STATE'(3'b010);
    localparam logic [WIDTH_STATE-1:0] ST_SD = WIDTH_STATE'(3'b011);
    localparam logic [WIDTH_STATE-1:0] ST_I  = WIDTH_STATE'(3'b100);

    if (NUM_WAYS < 2 || (NUM_WAYS & (NUM_WAYS - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("cache_controller_nway: illegal NUM_WAYS or TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        ALLOCATE,
        INVALIDATE
    } fsm_t;

    fsm_t                 state;
    logic                 op_write;   // latched request type: 1 = write
    logic [WIDTH_WAY-1:0] way_q;      // way used by the wait states
    logic [WIDTH_WAY-1:0] rr_ptr;
    logic                 rr_used;    // current victim was taken from rr_ptr

    // ---------------- hit / victim resolution ----------------
    logic                   hit_any;
    logic [WIDTH_WAY-1:0]   hit_way;
    logic [WIDTH_STATE-1:0] hit_state;
    logic                   inv_any;
    logic [WIDTH_WAY-1:0]   inv_way;
    logic [WIDTH_WAY-1:0]   victim;
    logic [WIDTH_STATE-1:0] victim_state;
    logic [WIDTH_STATE-1:0] ws;
    logic                   hit_shared;
    logic                   victim_dirty;

    // NOTE: every variable gets a default at the top of the block. This keeps
    // a path that skips an assignment from inferring a latch.
    always_comb begin
        hit_any      = 1'b0;
        hit_way      = '0;
        hit_state    = ST_I;
        inv_any      = 1'b0;
        inv_way      = '0;
        victim_state = ST_I;
        ws           = ST_I;
        // The loop scans downward, so the lowest matching index is written last.
        for (int k = NUM_WAYS - 1; k >= 0; k--) begin
            ws = bus.way_state[k*WIDTH_STATE +: WIDTH_STATE];
            if (bus.way_hit[k] && ws != ST_I) begin
                hit_any   = 1'b1;
                hit_way   = WIDTH_WAY'(k);
                hit_state = ws;
            end
            if (ws == ST_I) begin
                inv_any = 1'b1;
                inv_way = WIDTH_WAY'(k);
            end
        end
        victim = inv_any ? inv_way : rr_ptr;
        for (int k = 0; k < NUM_WAYS; k++) begin
            if (WIDTH_WAY'(k) == victim) begin
                victim_state = bus.way_state[k*WIDTH_STATE +: WIDTH_STATE];
            end
        end
        hit_shared   = (hit_state == ST_SC) || (hit_state == ST_SD);
        victim_dirty = (victim_state == ST_UD) || (victim_state == ST_SD);
    end

    // ---------------- optional ACE wait timeout ----------------
    logic timed_out;
`ifdef CACHE_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] timer;
    logic               waiting;

    assign waiting = (state == WRITEBACK) || (state == ALLOCATE) || (state == INVALIDATE);
    // This cycle is the TIMEOUT_CYCLES-th cycle without ace_ready. An ace_ready
    // arriving in the same cycle still completes normally.
    assign timed_out = waiting && !bus.ace_ready && (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (waiting && !bus.ace_ready && !timed_out) begin
            timer <= timer + 1'b1;
        end else begin
            // Clears on every exit from a wait state. The next wait then starts at 0.
            timer <= '0;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments only. All
    // registers therefore update together on the edge, whatever order they
    // are written in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_write <= 1'b0;
            way_q    <= '0;
            rr_ptr   <= '0;
            rr_used  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_request[1] == 1'b0) begin
                        op_write <= bus.cpu_request[0];
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit_any) begin
                        way_q <= hit_way;
                        state <= (op_write && hit_shared) ? INVALIDATE : IDLE;
                    end else begin
                        way_q   <= victim;
                        rr_used <= !inv_any;
                        state   <= victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (bus.ace_ready)  state <= ALLOCATE;
                    else if (timed_out) state <= IDLE;
                end
                ALLOCATE: begin
                    if (bus.ace_ready) begin
                        // Only a pointer-chosen victim advances the pointer.
                        if (rr_used) rr_ptr <= rr_ptr + 1'b1;
                        rr_used <= 1'b0;
                        state   <= LOOKUP;
                    end else if (timed_out) begin
                        rr_used <= 1'b0;
                        state   <= IDLE;
                    end
                end
                INVALIDATE: begin
                    if (bus.ace_ready || timed_out) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- outputs (from state + inputs) ----------------
    always_comb begin
        bus.read_req                = 1'b0;
        bus.write_req               = 1'b0;
        bus.invalid_req             = 1'b0;
        bus.write_from_cpu          = 1'b0;
        bus.write_from_interconnect = 1'b0;
        bus.state_sel               = 1'b0;
        bus.new_state               = '0;
        bus.way_sel                 = '0;
        bus.cache_complete          = 1'b0;
        bus.cache_ready             = 1'b0;
        bus.cache_error             = 1'b0;
        if (!reset) begin
            bus.new_state   = ST_I;
            bus.cache_error = timed_out;
            case (state)
                IDLE: bus.cache_ready = 1'b1;
                LOOKUP: begin
                    if (hit_any) begin
                        bus.way_sel = hit_way;
                        if (!op_write) begin
                            bus.cache_complete = 1'b1;
                        end else if (!hit_shared) begin
                            bus.write_from_cpu = 1'b1;
                            bus.state_sel      = 1'b1;
                            bus.new_state      = ST_UD;
                            bus.cache_complete = 1'b1;
                        end
                    end else begin
                        bus.way_sel = victim;
                    end
                end
                WRITEBACK: begin
                    bus.way_sel   = way_q;
                    bus.write_req = 1'b1;
                    if (bus.ace_ready) begin
                        bus.state_sel = 1'b1;
                        bus.new_state = ST_I;
                    end
                end
                ALLOCATE: begin
                    bus.way_sel  = way_q;
                    bus.read_req = 1'b1;
                    if (bus.ace_ready) begin
                        bus.write_from_interconnect = 1'b1;
                        bus.state_sel               = 1'b1;
                        bus.new_state               = ST_UC;
                    end
                end
                INVALIDATE: begin
                    bus.way_sel     = way_q;
                    bus.invalid_req = 1'b1;
                    if (bus.ace_ready) begin
                        bus.write_from_cpu = 1'b1;
                        bus.state_sel      = 1'b1;
                        bus.new_state      = ST_UD;
                        bus.cache_complete = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_controller_nway.sv
// ---------------------------------------------------------------------------
// tb_cache_controller_nway
//   Self-checking bench for cache_controller_nway (4 ways, 3-bit states).
//   Each test builds a per-cycle stimulus list and pushes the expected output
//   vector for each cycle onto a scoreboard. It then drives the cycles and
//   pops each expectation when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_cache_controller_nway;
    localparam int NW = 4;
    localparam int WS = 3;
`ifdef CACHE_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    localparam logic [2:0] UC = 3'b000, UD = 3'b001, SC = 3'b010, SD = 3'b011, SI = 3'b100;
    localparam logic [1:0] RD = 2'b00, WR = 2'b01, NOP = 2'b11;

    typedef struct packed {
        logic        rst;
        logic [1:0]  req;
        logic [3:0]  hit;
        logic [11:0] st;
        logic        ace;
    } stim_t;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic       inv;
        logic       wfc;
        logic       wfi;
        logic       ss;
        logic [2:0] ns;
        logic [1:0] way;
        logic       cmp;
        logic       rdy;
        logic       err;
    } out_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_controller_nway_if #(.NUM_WAYS(NW), .WIDTH_STATE(WS)) bus ();

    cache_controller_nway #(
        .NUM_WAYS(NW), .WIDTH_STATE(WS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    stim_t stim_q[$];
    out_t  sb[$];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [11:0] st4(logic [2:0] w0, logic [2:0] w1, logic [2:0] w2, logic [2:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [11:0] all4(logic [2:0] s);
        return {s, s, s, s};
    endfunction

    function automatic stim_t S(logic rst, logic [1:0] req, logic [3:0] hit, logic [11:0] st, logic ace);
        stim_t s;
        s.rst = rst; s.req = req; s.hit = hit; s.st = st; s.ace = ace;
        return s;
    endfunction

    function automatic out_t O(logic rd, logic wr, logic inv, logic wfc, logic wfi, logic ss,
                               logic [2:0] ns, logic [1:0] way, logic cmp, logic rdy, logic err);
        out_t o;
        o.rd = rd; o.wr = wr; o.inv = inv; o.wfc = wfc; o.wfi = wfi; o.ss = ss;
        o.ns = ns; o.way = way; o.cmp = cmp; o.rdy = rdy; o.err = err;
        return o;
    endfunction

    // Expected vectors for each recurring phase
    function automatic out_t e_zero();              return O(0,0,0,0,0,0,3'b000,2'd0,0,0,0); endfunction
    function automatic out_t e_idle();              return O(0,0,0,0,0,0,SI,2'd0,0,1,0);     endfunction
    function automatic out_t e_look(logic [1:0] w); return O(0,0,0,0,0,0,SI,w,0,0,0);        endfunction
    function automatic out_t e_rdhit(logic [1:0] w);return O(0,0,0,0,0,0,SI,w,1,0,0);        endfunction
    function automatic out_t e_wrhit(logic [1:0] w);return O(0,0,0,1,0,1,UD,w,1,0,0);        endfunction
    function automatic out_t e_wbw(logic [1:0] w);  return O(0,1,0,0,0,0,SI,w,0,0,0);        endfunction
    function automatic out_t e_wbd(logic [1:0] w);  return O(0,1,0,0,0,1,SI,w,0,0,0);        endfunction
    function automatic out_t e_alw(logic [1:0] w);  return O(1,0,0,0,0,0,SI,w,0,0,0);        endfunction
    function automatic out_t e_ald(logic [1:0] w);  return O(1,0,0,0,1,1,UC,w,0,0,0);        endfunction
    function automatic out_t e_invw(logic [1:0] w); return O(0,0,1,0,0,0,SI,w,0,0,0);        endfunction
    function automatic out_t e_invd(logic [1:0] w); return O(0,0,1,1,0,1,UD,w,1,0,0);        endfunction

    function automatic out_t observe();
        return O(bus.read_req, bus.write_req, bus.invalid_req, bus.write_from_cpu,
                 bus.write_from_interconnect, bus.state_sel, bus.new_state, bus.way_sel,
                 bus.cache_complete, bus.cache_ready, bus.cache_error);
    endfunction

    task automatic push(stim_t s, out_t e);
        stim_q.push_back(s);
        sb.push_back(e);
    endtask

    // Drives one cycle at the falling edge and leaves the inputs settled
    task automatic apply(stim_t s);
        @(negedge clk);
        reset           = s.rst;
        bus.cpu_request = s.req;
        bus.way_hit     = s.hit;
        bus.way_state   = s.st;
        bus.ace_ready   = s.ace;
        #2;
    endtask

    // Clean read miss of victim w: request, lookup, immediate fill, replay hit
    task automatic q_read_miss(logic [11:0] st, logic [1:0] w);
        logic [3:0] oh;
        oh = 4'b0001 << w;
        push(S(0, RD,  4'b0000, st,        0), e_idle());
        push(S(0, NOP, 4'b0000, st,        0), e_look(w));
        push(S(0, NOP, 4'b0000, st,        1), e_ald(w));
        push(S(0, NOP, oh,      all4(UC),  0), e_rdhit(w));
    endtask

    task automatic test_reset();
        stim_t s; out_t exp, got; int n;
        push(S(1, NOP, 4'b0000, all4(SI), 0), e_zero());
        push(S(1, RD,  4'b1111, all4(UC), 1), e_zero());
        push(S(0, 2'b10, 4'b0000, all4(SI), 1), e_idle());  // no-op request, stray ace_ready
        push(S(0, NOP, 4'b0000, all4(SI), 1), e_idle());
        n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); apply(s);
            exp = sb.pop_front(); got = observe(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL test_reset step %0d: got %b required %b", n, got, exp);
            end
            n++;
        end
    endtask

    task automatic test_read_hit();
        stim_t s; out_t exp, got; int n;
        push(S(0, RD,  4'b0000, all4(SI), 0), e_idle());
        push(S(0, NOP, 4'b0100, st4(SI, SI, SC, SI), 0), e_rdhit(2'd2));
        push(S(0, RD,  4'b0000, all4(SI), 0), e_idle());
        push(S(0, NOP, 4'b1010, all4(UC), 0), e_rdhit(2'd1));          // lowest of two hits
        push(S(0, RD,  4'b0000, all4(SI), 0), e_idle());
        push(S(0, NOP, 4'b0011, st4(SI, SC, UC, UC), 0), e_rdhit(2'd1)); // way0 tag match but invalid
        push(S(0, NOP, 4'b0000, all4(SI), 0), e_idle());
        n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); apply(s);
            exp = sb.pop_front(); got = observe(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL test_read_hit step %0d: got %b required %b", n, got, exp);
            end
            n++;
        end
    endtask

    task automatic test_write_hit();
        stim_t s; out_t exp, got; int n;
        push(S(0, WR,  4'b0000, all4(SI), 0), e_idle());
        push(S(0, NOP, 4'b1000, all4(UC), 0), e_wrhit(2'd3));           // unique: immediate
        push(S(0, WR,  4'b0000, all4(SI), 0), e_idle());
        push(S(0, NOP, 4'b0010, st4(UC, SD, UC, UC), 0), e_look(2'd1)); // shared: invalidate
        push(S(0, NOP, 4'b0000, all4(SI), 0), e_invw(2'd1));
        push(S(0, RD,  4'b0000, all4(SI), 0), e_invw(2'd1));            // request ignored
        push(S(0, NOP, 4'b0000, all4(SI), 1), e_invd(2'd1));
        push(S(0, NOP, 4'b0000, all4(SI), 0), e_idle());
        n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); apply(s);
            exp = sb.pop_front(); got = observe(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL test_write_hit step %0d: got %b required %b", n, got, exp);
            end
            n++;
        end
    endtask

    task automatic test_write_miss_dirty();
        stim_t s; out_t exp, got; int n;
        push(S(1, NOP, 4'b0000, all4(SI), 0), e_zero());                // rr_ptr = 0
        push(S(0, WR,  4'b0000, all4(UD), 0), e_idle());
        push(S(0, NOP, 4'b0000, all4(UD), 0), e_look(2'd0));
        push(S(0, NOP, 4'b0000, all4(UD), 0), e_wbw(2'd0));
        push(S(0, NOP, 4'b0000, all4(UD), 1), e_wbd(2'd0));
        push(S(0, NOP, 4'b0000, all4(UD), 0), e_alw(2'd0));
        push(S(0, NOP, 4'b0000, all4(UD), 1), e_ald(2'd0));
        push(S(0, NOP, 4'b0001, st4(UC, UD, UD, UD), 0), e_wrhit(2'd0)); // replay
        q_read_miss(all4(UC), 2'd1);                                     // rr_ptr now 1
        push(S(0, NOP, 4'b0000, all4(SI), 0), e_idle());
        n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); apply(s);
            exp = sb.pop_front(); got = observe(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL test_write_miss_dirty step %0d: got %b required %b", n, got, exp);
            end
            n++;
        end
    endtask

    task automatic test_round_robin();
        stim_t s; out_t exp, got; int n;
        push(S(1, NOP, 4'b0000, all4(SI), 0), e_zero());
        for (int v = 0; v < 5; v++) q_read_miss(all4(UC), 2'(v % 4));   // 0,1,2,3,0
        q_read_miss(st4(UC, UC, UC, SI), 2'd3);                           // invalid way wins
        q_read_miss(st4(UC, UC, SI, SI), 2'd2);                           // lowest invalid
        q_read_miss(all4(UC), 2'd1);                                      // pointer held at 1
        push(S(0, NOP, 4'b0000, all4(SI), 0), e_idle());
        n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); apply(s);
            exp = sb.pop_front(); got = observe(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL test_round_robin step %0d: got %b required %b", n, got, exp);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_op();
        stim_t s; out_t exp, got; int n;
        // rr_ptr is 2 here
        push(S(0, WR,  4'b0000, all4(UD), 0), e_idle());
        push(S(0, NOP, 4'b0000, all4(UD), 0), e_look(2'd2));
        push(S(0, NOP, 4'b0000, all4(UD), 0), e_wbw(2'd2));
        push(S(1, NOP, 4'b0000, all4(UD), 1), e_zero());
        push(S(0, NOP, 4'b0000, all4(UD), 1), e_idle());
        q_read_miss(all4(UC), 2'd0);                                      // pointer back at 0
        push(S(0, NOP, 4'b0000, all4(SI), 0), e_idle());
        n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); apply(s);
            exp = sb.pop_front(); got = observe(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL test_reset_mid_op step %0d: got %b required %b", n, got, exp);
            end
            n++;
        end
    endtask

    task automatic test_timeout();
        stim_t s; out_t exp, got; int n;
        // rr_ptr is 1 here
        push(S(0, WR,  4'b0000, all4(UD), 0), e_idle());
        push(S(0, NOP, 4'b0000, all4(UD), 0), e_look(2'd1));
`ifdef CACHE_TIMEOUT_EN
        for (int i = 0; i < TO - 1; i++) push(S(0, NOP, 4'b0000, all4(UD), 0), e_wbw(2'd1));
        push(S(0, NOP, 4'b0000, all4(UD), 0), O(0,1,0,0,0,0,SI,2'd1,0,0,1));
        push(S(0, WR,  4'b0000, all4(UD), 0), e_idle());
        push(S(0, NOP, 4'b0000, all4(UD), 0), e_look(2'd1));
        for (int i = 0; i < TO - 1; i++) push(S(0, NOP, 4'b0000, all4(UD), 0), e_wbw(2'd1));
        push(S(0, NOP, 4'b0000, all4(UD), 1), e_wbd(2'd1));               // ready wins
`else
        for (int i = 0; i < 12; i++) push(S(0, NOP, 4'b0000, all4(UD), 0), e_wbw(2'd1));
        push(S(0, NOP, 4'b0000, all4(UD), 1), e_wbd(2'd1));
`endif
        push(S(0, NOP, 4'b0000, all4(UD), 1), e_ald(2'd1));
        push(S(0, NOP, 4'b0010, st4(UD, UC, UD, UD), 0), e_wrhit(2'd1));
        push(S(0, NOP, 4'b0000, all4(SI), 0), e_idle());
        n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); apply(s);
            exp = sb.pop_front(); got = observe(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL test_timeout step %0d: got %b required %b", n, got, exp);
            end
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        bus.cpu_request = NOP;
        bus.way_hit     = '0;
        bus.way_state   = all4(SI);
        bus.ace_ready   = 1'b0;
        test_reset();
        test_read_hit();
        test_write_hit();
        test_write_miss_dirty();
        test_round_robin();
        test_reset_mid_op();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
